// File: rtl/panda_div_if.sv
// panda_pkg: shared types for the panda divider.
//   div_operator_e : 2-bit operator code (DIV, DIVU, REM, REMU).
//
// panda_div_if: request/result handshake bundle for panda_div.
//   valid_i / ready_o         request handshake (accepted when both high)
//   operator_i                operation, sampled at acceptance
//   operand_a_i / operand_b_i dividend / divisor, sampled at acceptance
//   valid_o / ready_i         result handshake (consumed when both high)
//   result_o                  quotient or remainder, 0 while valid_o is low
// The slave modport is the divider side; the master modport is the requester.

package panda_pkg;
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_operator_e;
endpackage

interface panda_div_if;
    import panda_pkg::*;

    logic          valid_i;
    logic          ready_o;
    div_operator_e operator_i;
    logic [31:0]   operand_a_i;
    logic [31:0]   operand_b_i;
    logic          valid_o;
    logic          ready_i;
    logic [31:0]   result_o;

    modport slave (
        input  valid_i, operator_i, operand_a_i, operand_b_i, ready_i,
        output ready_o, valid_o, result_o
    );

    modport master (
        output valid_i, operator_i, operand_a_i, operand_b_i, ready_i,
        input  ready_o, valid_o, result_o
    );
endinterface

// File: rtl/panda_div.sv
// panda_div: 32-bit iterative divider (restoring, radix-2, one quotient bit
// per clock, MSB first).
//   clk_i   clock, all state changes on the rising edge
//   rst_i   synchronous active-high reset, highest priority
//   flush_i abandons any in-flight or completed operation
//   bus     panda_div_if.slave request/result handshake
// Divide-by-zero and signed overflow bypass the iteration and complete on the
// accepting edge. Normal operations complete 32 edges after acceptance.

module panda_div
    import panda_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    panda_div_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e      state_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] quo_reg;     // holds the dividend magnitude, shifted out as quotient bits shift in
    logic [32:0] rem_reg;     // partial remainder, 33 bits so the trial subtraction keeps its borrow
    logic [31:0] div_reg;     // divisor magnitude
    logic        rem_sel_reg; // 1: return remainder, 0: return quotient
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic [31:0] result_reg;
    logic        valid_reg;
    logic        ready_reg;

    // Acceptance-side decode of the incoming request.
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        b_zero;
    logic        ovf;
    logic [31:0] special_result;

    always_comb begin
        is_signed = ~bus.operator_i[0];
        a_neg     = is_signed & bus.operand_a_i[31];
        b_neg     = is_signed & bus.operand_b_i[31];
        mag_a     = a_neg ? (32'd0 - bus.operand_a_i) : bus.operand_a_i;
        mag_b     = b_neg ? (32'd0 - bus.operand_b_i) : bus.operand_b_i;
        b_zero    = (bus.operand_b_i == 32'd0);
        ovf       = is_signed && (bus.operand_a_i == 32'h8000_0000)
                              && (bus.operand_b_i == 32'hFFFF_FFFF);
        special_result = 32'd0;
        if (b_zero) begin
            special_result = bus.operator_i[1] ? bus.operand_a_i : 32'hFFFF_FFFF;
        end else if (ovf) begin
            special_result = bus.operator_i[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One restoring step: shift in the next dividend bit, try to subtract.
    // The extra top bit of shifted/diff is always zero on entry; diff[33]
    // is the borrow that decides the quotient bit.
    logic [33:0] shifted;
    logic [33:0] diff;
    logic [32:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    always_comb begin
        shifted = {rem_reg, quo_reg[31]};
        diff    = shifted - {2'b00, div_reg};
        if (!diff[33]) begin
            rem_step = diff[32:0];
            quo_step = {quo_reg[30:0], 1'b1};
        end else begin
            rem_step = shifted[32:0];
            quo_step = {quo_reg[30:0], 1'b0};
        end
        // Sign fix-up: quotient negative when signs differ, remainder follows the dividend.
        q_fix = neg_q_reg ? (32'd0 - quo_step) : quo_step;
        r_fix = neg_r_reg ? (32'd0 - rem_step[31:0]) : rem_step[31:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= 5'd0;
            quo_reg     <= 32'd0;
            rem_reg     <= 33'd0;
            div_reg     <= 32'd0;
            rem_sel_reg <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            result_reg  <= 32'd0;
            valid_reg   <= 1'b0;
            ready_reg   <= 1'b1;    // masked by rst_i at the output, so it shows up right after release
        end else if (flush_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= 5'd0;
            result_reg <= 32'd0;
            valid_reg  <= 1'b0;
            ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.valid_i) begin
                        rem_sel_reg <= bus.operator_i[1];
                        neg_q_reg   <= a_neg ^ b_neg;
                        neg_r_reg   <= a_neg;
                        quo_reg     <= mag_a;
                        div_reg     <= mag_b;
                        rem_reg     <= 33'd0;
                        cnt_reg     <= 5'd0;
                        ready_reg   <= 1'b0;
                        if (b_zero || ovf) begin
                            state_reg  <= DONE;
                            result_reg <= special_result;
                            valid_reg  <= 1'b1;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    quo_reg <= quo_step;
                    rem_reg <= rem_step;
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) begin
                        state_reg  <= DONE;
                        result_reg <= rem_sel_reg ? r_fix : q_fix;
                        valid_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        state_reg  <= IDLE;
                        result_reg <= 32'd0;
                        valid_reg  <= 1'b0;
                        ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    result_reg <= 32'd0;
                    valid_reg  <= 1'b0;
                    ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o  = ready_reg & ~rst_i;
    assign bus.valid_o  = valid_reg;
    assign bus.result_o = result_reg;

endmodule

// File: tb/tb_panda_div.sv
// tb_panda_div: directed-vector bench for panda_div with hand-computed
// expected results. Latency is counted in rising edges after the accepting
// edge: 32 for the iterative path, 0 for divide-by-zero/overflow (the
// accepting edge itself moves the divider to DONE).

module tb_panda_div;
    import panda_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    logic flush_i;

    panda_div_if bus ();

    panda_div u_dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .bus     (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request, wait for the result, hold ready_i low for 'hold'
    // cycles, then consume it. Called #1 after a rising edge.
    task automatic run_op(input string tag, input div_operator_e op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat,
                          input int hold);
        int n;
        check({tag, "/ready_before"}, {31'd0, bus.ready_o}, 32'd1);
        bus.valid_i     = 1'b1;
        bus.operator_i  = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        step();                          // accepting edge
        bus.valid_i     = 1'b0;
        bus.operand_a_i = ~a;            // must be ignored after acceptance
        bus.operand_b_i = b ^ 32'h5A5A_0001;
        bus.operator_i  = DIVU;
        n = 0;
        while (!bus.valid_o && n < 100) begin
            if (bus.result_o !== 32'd0) check({tag, "/result_zero_while_busy"}, bus.result_o, 32'd0);
            step();
            n++;
        end
        check({tag, "/latency"}, n, exp_lat);
        check({tag, "/result"}, bus.result_o, exp_res);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "/hold_result"}, bus.result_o, exp_res);
            check({tag, "/hold_ready"}, {31'd0, bus.ready_o}, 32'd0);
        end
        bus.ready_i = 1'b1;
        step();                          // handshake edge
        bus.ready_i = 1'b0;
        check({tag, "/valid_after"}, {31'd0, bus.valid_o}, 32'd0);
        check({tag, "/ready_after"}, {31'd0, bus.ready_o}, 32'd1);
        $display("op %-10s a=%h b=%h result=%h latency=%0d", tag, a, b, exp_res, n);
    endtask

    initial begin
        int seen;
        rst_i           = 1'b1;
        flush_i         = 1'b0;
        bus.valid_i     = 1'b0;
        bus.ready_i     = 1'b0;
        bus.operator_i  = DIV;
        bus.operand_a_i = 32'd0;
        bus.operand_b_i = 32'd0;
        step();
        step();
        check("reset/ready", {31'd0, bus.ready_o}, 32'd0);
        check("reset/valid", {31'd0, bus.valid_o}, 32'd0);
        check("reset/result", bus.result_o, 32'd0);
        rst_i = 1'b0;
        #1;
        check("release/ready", {31'd0, bus.ready_o}, 32'd1);
        step();

        // Iterative path
        run_op("div_neg",  DIV,  32'hFFFF_FFC2, 32'd5,        32'hFFFF_FFF4, 32, 0);
        run_op("rem_neg",  REM,  32'hFFFF_FFC2, 32'd5,        32'hFFFF_FFFE, 32, 0);
        run_op("divu_max", DIVU, 32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF, 32, 0);
        run_op("remu_max", REMU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32, 0);
        run_op("divu_a0",  DIVU, 32'd0,         32'd7,        32'd0,         32, 0);
        run_op("rem_a0",   REM,  32'd0,         32'hFFFF_FFF9, 32'd0,        32, 0);
        run_op("rem_posneg", REM, 32'd7,        32'hFFFF_FFFE, 32'd1,        32, 0);
        // Stall in DONE
        run_op("div_nn_hold", DIV, 32'hFFFF_FF7A, 32'hFFFF_FFA6, 32'd1,      32, 5);

        // Early-exit path
        run_op("div_by0",  DIV,  32'd30,        32'd0,        32'hFFFF_FFFF, 0, 0);
        run_op("remu_by0", REMU, 32'd30,        32'd0,        32'h0000_001E, 0, 0);
        run_op("div_ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
        run_op("rem_ovf",  REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
        run_op("divu_nobvf", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,     32, 0);

        // Flush at counter 10 in CALC
        bus.valid_i = 1'b1; bus.operator_i = DIVU;
        bus.operand_a_i = 32'd1000; bus.operand_b_i = 32'd3;
        step();
        bus.valid_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush/ready", {31'd0, bus.ready_o}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_o) seen++;
            step();
        end
        check("flush/no_valid", seen, 0);
        $display("op flush_calc  valid pulses after flush=%0d", seen);

        // Reset while in DONE
        bus.valid_i = 1'b1; bus.operator_i = DIV;
        bus.operand_a_i = 32'd9; bus.operand_b_i = 32'd0;
        step();
        bus.valid_i = 1'b0;
        check("rstdone/valid_pre", {31'd0, bus.valid_o}, 32'd1);
        rst_i = 1'b1;
        bus.ready_i = 1'b1;
        step();
        bus.ready_i = 1'b0;
        check("rstdone/valid", {31'd0, bus.valid_o}, 32'd0);
        check("rstdone/ready_in_rst", {31'd0, bus.ready_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        check("rstdone/ready_release", {31'd0, bus.ready_o}, 32'd1);
        $display("op reset_done  valid=%0d ready=%0d", bus.valid_o, bus.ready_o);
        step();

        // Reset mid-CALC: nothing may complete afterwards
        bus.valid_i = 1'b1; bus.operator_i = DIV;
        bus.operand_a_i = 32'd100; bus.operand_b_i = 32'd7;
        step();
        bus.valid_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_o) seen++;
            step();
        end
        check("rstcalc/no_valid", seen, 0);
        $display("op reset_calc  valid pulses after reset=%0d", seen);

        // Still functional afterwards
        run_op("div_after", DIV, 32'd100, 32'd7, 32'd14, 32, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
